// File: rtl/video_loop_pkg.sv
// rtl/video_loop_pkg.sv - shared defaults, delay limits and lock FSM states for the video loop-through pipe
package video_loop_pkg;

    localparam int DATA_W_DEF    = 24;
    localparam int H_W_DEF       = 12;
    localparam int V_W_DEF       = 12;
    localparam int DELAY_MIN     = 2;
    localparam int DELAY_MAX     = 16;
    localparam int BLANK_VAL_DEF = 0;
    localparam int STABLE_W      = 4;

    typedef enum logic [1:0] {
        ST_IDLE,
        ST_ACQUIRE,
        ST_LOCKED
    } lock_state_t;

    function automatic int clamp_delay(input int d);
        if (d < DELAY_MIN) begin
            return DELAY_MIN;
        end
        if (d > DELAY_MAX) begin
            return DELAY_MAX;
        end
        return d;
    endfunction

endpackage

// File: rtl/video_timing_meas.sv
// rtl/video_timing_meas.sv - active line/frame measurement and lock FSM; VIDEO_LOOP_TIMEOUT_EN adds a vs watchdog
module video_timing_meas
    import video_loop_pkg::*;
#(
    parameter int H_W           = H_W_DEF,
    parameter int V_W           = V_W_DEF,
    parameter int STABLE_FRAMES = 2,
    parameter int VS_POL        = 1
`ifdef VIDEO_LOOP_TIMEOUT_EN
    ,
    parameter int TIMEOUT_CLKS  = 4000000
`endif
) (
    input  logic           i_clk,
    input  logic           i_rst,
    input  logic           i_vs,
    input  logic           i_de,
    output logic           o_locked,
    output logic [H_W-1:0] o_h_active,
    output logic [V_W-1:0] o_v_active,
    output logic           o_frame_err
);

    localparam logic                VS_ACT     = (VS_POL != 0);
    localparam logic [STABLE_W-1:0] STABLE_MAX = STABLE_W'(STABLE_FRAMES);

    lock_state_t r_state;
    lock_state_t w_state_nxt;

    logic                r_vs_d;
    logic                r_de_d;
    logic [H_W-1:0]      r_pix_cnt;
    logic [H_W-1:0]      r_ref_h;
    logic [H_W-1:0]      r_prev_h;
    logic [H_W-1:0]      r_h_active;
    logic [V_W-1:0]      r_line_cnt;
    logic [V_W-1:0]      r_prev_v;
    logic [V_W-1:0]      r_v_active;
    logic                r_incons;
    logic                r_first;
    logic                r_frame_err;
    logic [STABLE_W-1:0] r_stable_cnt;

    logic                w_vs_lead;
    logic                w_de_fall;
    logic                w_timeout;
    logic [V_W-1:0]      w_line_cnt;
    logic [H_W-1:0]      w_ref_h;
    logic                w_incons;
    logic                w_valid;
    logic                w_match;
    logic [STABLE_W-1:0] w_stable_nxt;

    assign w_vs_lead = (i_vs == VS_ACT) && (r_vs_d != VS_ACT);
    assign w_de_fall = r_de_d && !i_de;

    // A line closing in the same cycle as vs_lead is folded in before the frame is judged.
    assign w_line_cnt = (w_de_fall && (r_line_cnt != '1)) ? r_line_cnt + 1'b1 : r_line_cnt;
    assign w_ref_h    = (w_de_fall && (r_line_cnt == '0)) ? r_pix_cnt : r_ref_h;
    assign w_incons   = r_incons ||
                        (w_de_fall && (r_line_cnt != '0) && (r_pix_cnt != r_ref_h));
    assign w_valid    = (w_line_cnt != '0) && !w_incons;
    assign w_match    = w_valid && (w_ref_h == r_prev_h) && (w_line_cnt == r_prev_v);

    always_comb begin
        w_stable_nxt = '0;
        if (w_match) begin
            w_stable_nxt = (r_stable_cnt >= STABLE_MAX) ? STABLE_MAX : r_stable_cnt + 1'b1;
        end else if (w_valid) begin
            w_stable_nxt = STABLE_W'(1);
        end
    end

`ifdef VIDEO_LOOP_TIMEOUT_EN
    localparam logic [31:0] TO_LIMIT = 32'(TIMEOUT_CLKS);

    logic [31:0] r_to_cnt;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_to_cnt <= '0;
        end else if (w_vs_lead) begin
            r_to_cnt <= '0;
        end else if (r_to_cnt != TO_LIMIT) begin
            r_to_cnt <= r_to_cnt + 32'd1;
        end
    end

    // Fires once, on the edge where the counter lands on the limit.
    assign w_timeout = !w_vs_lead && (r_to_cnt == TO_LIMIT - 32'd1);
`else
    assign w_timeout = 1'b0;
`endif

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        if (w_vs_lead) begin
            if (r_state == ST_IDLE) begin
                w_state_nxt = ST_ACQUIRE;
            end else if (w_stable_nxt >= STABLE_MAX) begin
                w_state_nxt = ST_LOCKED;
            end else begin
                w_state_nxt = ST_ACQUIRE;
            end
        end else if (w_timeout) begin
            w_state_nxt = ST_IDLE;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_vs_d       <= 1'b0;
            r_de_d       <= 1'b0;
            r_pix_cnt    <= '0;
            r_ref_h      <= '0;
            r_prev_h     <= '0;
            r_h_active   <= '0;
            r_line_cnt   <= '0;
            r_prev_v     <= '0;
            r_v_active   <= '0;
            r_incons     <= 1'b0;
            r_first      <= 1'b0;
            r_frame_err  <= 1'b0;
            r_stable_cnt <= '0;
        end else begin
            r_vs_d      <= i_vs;
            r_de_d      <= i_de;
            r_frame_err <= 1'b0;
            if (w_vs_lead) begin
                r_pix_cnt  <= '0;
                r_line_cnt <= '0;
                r_incons   <= 1'b0;
                if (r_state == ST_IDLE) begin
                    r_first <= 1'b1;
                end else begin
                    r_h_active   <= w_ref_h;
                    r_v_active   <= w_line_cnt;
                    r_stable_cnt <= w_stable_nxt;
                    r_frame_err  <= !w_match && !r_first;
                    r_first      <= 1'b0;
                    r_prev_h     <= w_ref_h;
                    r_prev_v     <= w_line_cnt;
                end
            end else begin
                if (w_timeout) begin
                    r_stable_cnt <= '0;
                end
                if (w_de_fall) begin
                    r_pix_cnt  <= '0;
                    r_line_cnt <= w_line_cnt;
                    r_ref_h    <= w_ref_h;
                    r_incons   <= w_incons;
                end else if (i_de && (r_pix_cnt != '1)) begin
                    r_pix_cnt <= r_pix_cnt + 1'b1;
                end
            end
        end
    end

    assign o_locked    = (r_state == ST_LOCKED);
    assign o_h_active  = r_h_active;
    assign o_v_active  = r_v_active;
    assign o_frame_err = r_frame_err;

endmodule

// File: rtl/video_loop_pipe.sv
// rtl/video_loop_pipe.sv - DELAY-stage video loop-through with frame-aligned lock muting; VIDEO_LOOP_TIMEOUT_EN enables vs watchdog
module video_loop_pipe
    import video_loop_pkg::*;
#(
    parameter int                DATA_W        = DATA_W_DEF,
    parameter int                DELAY         = 3,
    parameter int                H_W           = H_W_DEF,
    parameter int                V_W           = V_W_DEF,
    parameter int                STABLE_FRAMES = 2,
    parameter int                VS_POL        = 1,
    parameter logic [DATA_W-1:0] BLANK_VAL     = DATA_W'(BLANK_VAL_DEF)
`ifdef VIDEO_LOOP_TIMEOUT_EN
    ,
    parameter int                TIMEOUT_CLKS  = 4000000
`endif
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              vin_hs,
    input  logic              vin_vs,
    input  logic              vin_de,
    input  logic [DATA_W-1:0] vin_data,
    output logic              vout_hs,
    output logic              vout_vs,
    output logic              vout_de,
    output logic [DATA_W-1:0] vout_data,
    output logic              video_locked,
    output logic [H_W-1:0]    h_active,
    output logic [V_W-1:0]    v_active,
    output logic              frame_err
);

    localparam int D = clamp_delay(DELAY);

    logic [D-1:0]             r_hs_pipe;
    logic [D-1:0]             r_vs_pipe;
    logic [D-1:0]             r_de_pipe;
    logic [D-1:0][DATA_W-1:0] r_data_pipe;
    logic [D-2:0]             r_mute_pipe;
    logic                     w_locked;
    logic                     w_mute;

    video_timing_meas #(
        .H_W           (H_W),
        .V_W           (V_W),
        .STABLE_FRAMES (STABLE_FRAMES),
        .VS_POL        (VS_POL)
`ifdef VIDEO_LOOP_TIMEOUT_EN
        ,
        .TIMEOUT_CLKS  (TIMEOUT_CLKS)
`endif
    ) u_meas (
        .i_clk       (clk),
        .i_rst       (rst),
        .i_vs        (vin_vs),
        .i_de        (vin_de),
        .o_locked    (w_locked),
        .o_h_active  (h_active),
        .o_v_active  (v_active),
        .o_frame_err (frame_err)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            r_hs_pipe   <= '0;
            r_vs_pipe   <= '0;
            r_de_pipe   <= '0;
            r_data_pipe <= '0;
        end else begin
            r_hs_pipe   <= {r_hs_pipe[D-2:0], vin_hs};
            r_vs_pipe   <= {r_vs_pipe[D-2:0], vin_vs};
            r_de_pipe   <= {r_de_pipe[D-2:0], vin_de};
            r_data_pipe <= {r_data_pipe[D-2:0], vin_data};
        end
    end

    // Lock updates one cycle after vs_lead is sampled, so DELAY-1 more stages line it up with that sample.
    generate
        if (D == 2) begin : g_mute_one
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_mute_pipe <= '0;
                end else begin
                    r_mute_pipe <= ~w_locked;
                end
            end
        end else begin : g_mute_many
            always_ff @(posedge clk) begin
                if (rst) begin
                    r_mute_pipe <= '0;
                end else begin
                    r_mute_pipe <= {r_mute_pipe[D-3:0], ~w_locked};
                end
            end
        end
    endgenerate

    assign w_mute       = r_mute_pipe[D-2];
    assign vout_hs      = r_hs_pipe[D-1];
    assign vout_vs      = r_vs_pipe[D-1];
    assign vout_de      = r_de_pipe[D-1] && !w_mute;
    assign vout_data    = w_mute ? BLANK_VAL : r_data_pipe[D-1];
    assign video_locked = w_locked;

endmodule
